sprite_renderer: RTL and testbench

Parametrised, pipelined sprite pixel generator for the VGA display path. Given the current raster coordinate and a sprite origin, it outputs the sprite's RGB colour or a background colour. The bitmap is a run-time-loadable 2-bit-per-texel RAM with multiple animation frames and a programmable 4-entry palette. Adds horizontal mirroring, frame animation and a hit-flash effect, and replaces the hand-coded per-character pixel logic.

---
 rtl/sprite_renderer.sv | 131 +++++++++++++
 tb/tb_sprite_renderer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Pipelined sprite pixel generator: raster coordinate in, sprite texel colour or background out,
// two clocks later. Loadable 2-bit bitmap with animation frames, 4-entry palette, mirror and hit flash.
module sprite_renderer #(
   parameter int          SPR_W       = 16,
   parameter int          SPR_H       = 20,
   parameter int          SCALE       = 6,
   parameter int          FRAMES      = 2,
   parameter int          FRAME_HOLD  = 15,
   parameter int          FLASH_LEN   = 32,
   parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
   parameter logic [23:0] FLASH_COLOR = 24'hFF0000,
   localparam int         ADDR_W      = $clog2(FRAMES*SPR_W*SPR_H),
   localparam int         FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   input  logic [9:0]        x0,
   input  logic [8:0]        y0,
   input  logic              chosen,
   input  logic              hflip,
   input  logic              anim_en,
   input  logic              vsync_tick,
   input  logic              flash_start,
   input  logic              bm_we,
   input  logic [ADDR_W-1:0] bm_addr,
   input  logic [1:0]        bm_data,
   input  logic              pal_we,
   input  logic [1:0]        pal_idx,
   input  logic [23:0]       pal_data,
   output logic [7:0]        r,
   output logic [7:0]        g,
   output logic [7:0]        b,
   output logic              opaque,
   output logic [FW-1:0]     frame_idx
);

   localparam int DEPTH = FRAMES*SPR_W*SPR_H;
   localparam int HW    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int CW    = ($clog2(FLASH_LEN+1) > 3) ? $clog2(FLASH_LEN+1) : 3;

   logic [1:0]        bitmap [DEPTH];
   logic [23:0]       pal [4];
   logic [HW-1:0]     hold_cnt;
   logic [CW-1:0]     flash_cnt;
   logic              flash_on;

   logic [10:0]       xe, xlo, xhi;
   logic [9:0]        ye, ylo, yhi;
   logic              in_box;
   logic [9:0]        dx, tx_raw, tx;
   logic [8:0]        dy, ty;
   logic [ADDR_W-1:0] rd_addr;

   // v1 qualifies idx1: the texel read this cycle belongs to an enabled sprite box.
   // The pipeline has no back-pressure; every stage advances on every clock.
   logic              v1;
   logic [1:0]        idx1;

   always_comb begin
      xe     = {1'b0, x};
      xlo    = {1'b0, x0};
      xhi    = xlo + 11'(SPR_W*SCALE);
      ye     = {1'b0, y};
      ylo    = {1'b0, y0};
      yhi    = ylo + 10'(SPR_H*SCALE);
      in_box = (xe > xlo) && (xe <= xhi) && (ye > ylo) && (ye <= yhi);
      dx     = x - x0 - 10'd1;
      dy     = y - y0 - 9'd1;
      tx_raw = dx / 10'(SCALE);
      ty     = dy / 9'(SCALE);
      tx     = hflip ? (10'(SPR_W-1) - tx_raw) : tx_raw;
      rd_addr = '0;
      // Outside the box the divided offsets are meaningless, so park the read on address 0.
      if (in_box)
         rd_addr = ADDR_W'(32'(frame_idx)*SPR_W*SPR_H + 32'(ty)*SPR_W + 32'(tx));
   end

   assign flash_on = (flash_cnt != '0) & flash_cnt[2];

   // Bitmap RAM: read-before-write, so a same-address write is seen one read later.
   always_ff @(posedge clk) begin
      if (bm_we && (32'(bm_addr) < DEPTH))
         bitmap[bm_addr] <= bm_data;
      idx1 <= bitmap[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         {r, g, b} <= BG_COLOR;
         opaque    <= 1'b0;
         frame_idx <= '0;
         hold_cnt  <= '0;
         flash_cnt <= '0;
         v1        <= 1'b0;
         pal[0]    <= BG_COLOR;
         pal[1]    <= 24'h0F0F0F;
         pal[2]    <= 24'h404040;
         pal[3]    <= 24'h006600;
      end else begin
         v1 <= in_box & chosen;

         if (pal_we)
            pal[pal_idx] <= pal_data;

         if (vsync_tick && anim_en) begin
            if (hold_cnt == HW'(FRAME_HOLD-1)) begin
               hold_cnt  <= '0;
               frame_idx <= (frame_idx == FW'(FRAMES-1)) ? '0 : frame_idx + 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end

         if (flash_start)
            flash_cnt <= CW'(FLASH_LEN);
         else if (vsync_tick && (flash_cnt != '0))
            flash_cnt <= flash_cnt - 1'b1;

         if (!v1 || (idx1 == 2'd0)) begin
            {r, g, b} <= BG_COLOR;
            opaque    <= 1'b0;
         end else begin
            {r, g, b} <= flash_on ? FLASH_COLOR : pal[idx1];
            opaque    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised scoreboard bench for sprite_renderer: each issued pixel pushes its expected
// {opaque,rgb}; a monitor pops it when the result emerges two clocks later.
module tb_sprite_renderer;

   localparam int          SPR_W      = 16;
   localparam int          SPR_H      = 20;
   localparam int          SCALE      = 6;
   localparam int          FRAMES     = 2;
   localparam int          FRAME_HOLD = 15;
   localparam int          FLASH_LEN  = 32;
   localparam logic [23:0] BG         = 24'hFFFFFF;
   localparam logic [23:0] FL         = 24'hFF0000;
   localparam int          DEPTH      = FRAMES*SPR_W*SPR_H;
   localparam int          ADDR_W     = $clog2(DEPTH);
   localparam int          FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   logic              clk;
   logic              rst;
   logic [9:0]        x, x0;
   logic [8:0]        y, y0;
   logic              chosen, hflip, anim_en, vsync_tick, flash_start;
   logic              bm_we, pal_we;
   logic [ADDR_W-1:0] bm_addr;
   logic [1:0]        bm_data, pal_idx;
   logic [23:0]       pal_data;
   logic [7:0]        r, g, b;
   logic              opaque;
   logic [FW-1:0]     frame_idx;

   sprite_renderer #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE), .FRAMES(FRAMES),
      .FRAME_HOLD(FRAME_HOLD), .FLASH_LEN(FLASH_LEN), .BG_COLOR(BG), .FLASH_COLOR(FL)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .x0(x0), .y0(y0),
      .chosen(chosen), .hflip(hflip), .anim_en(anim_en), .vsync_tick(vsync_tick),
      .flash_start(flash_start), .bm_we(bm_we), .bm_addr(bm_addr), .bm_data(bm_data),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
      .r(r), .g(g), .b(b), .opaque(opaque), .frame_idx(frame_idx)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int          m_mem [DEPTH];
   logic [23:0] m_pal [4];
   int          m_frame, m_hold, m_flash;

   logic [24:0] exp_q [$];
   logic [1:0]  pipe = 2'b00;
   logic        issue;
   int          tests = 0;
   int          fails = 0;

   function automatic logic [24:0] model_pix(int px, int py, int ox, int oy, bit ch, bit hf);
      int tx, ty, idx;
      bit fon;
      if (!ch || px <= ox || px > ox + SPR_W*SCALE || py <= oy || py > oy + SPR_H*SCALE)
         return {1'b0, BG};
      tx = (px - ox - 1) / SCALE;
      ty = (py - oy - 1) / SCALE;
      if (hf) tx = SPR_W - 1 - tx;
      idx = m_mem[m_frame*SPR_W*SPR_H + ty*SPR_W + tx];
      if (idx == 0) return {1'b0, BG};
      fon = (m_flash != 0) && (((m_flash / 4) % 2) == 1);
      return {1'b1, fon ? FL : m_pal[idx]};
   endfunction

   task automatic model_reset();
      m_frame = 0; m_hold = 0; m_flash = 0;
      m_pal[0] = BG; m_pal[1] = 24'h0F0F0F; m_pal[2] = 24'h404040; m_pal[3] = 24'h006600;
   endtask

   // monitor
   always @(posedge clk) pipe <= {pipe[0], issue};

   always @(negedge clk) begin : monitor
      logic [24:0] act, e;
      if (pipe[1]) begin
         act = {opaque, r, g, b};
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pixel_unexpected: got %h with empty expected queue", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               fails++;
               $display("FAIL pixel: got {opaque,rgb}=%h expected %h", act, e);
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bg(string name);
      tests++;
      if ({opaque, r, g, b} !== {1'b0, BG}) begin
         fails++;
         $display("FAIL %s: got {opaque,rgb}=%h expected %h", name, {opaque, r, g, b}, {1'b0, BG});
      end
   endtask

   task automatic check_frame();
      tests++;
      if (frame_idx !== FW'(m_frame)) begin
         fails++;
         $display("FAIL frame_idx: got %0d expected %0d", frame_idx, m_frame);
      end
   endtask

   task automatic pix(int px, int py, int ox, int oy, bit ch, bit hf);
      x = 10'(px); y = 9'(py); x0 = 10'(ox); y0 = 9'(oy);
      chosen = ch; hflip = hf; issue = 1'b1;
      exp_q.push_back(model_pix(px, py, ox, oy, ch, hf));
      step();
      issue = 1'b0;
   endtask

   task automatic pix_wr(int px, int py, int ox, int oy, int wa, int wd);
      x = 10'(px); y = 9'(py); x0 = 10'(ox); y0 = 9'(oy);
      chosen = 1'b1; hflip = 1'b0; issue = 1'b1;
      bm_we = 1'b1; bm_addr = ADDR_W'(wa); bm_data = 2'(wd);
      exp_q.push_back(model_pix(px, py, ox, oy, 1'b1, 1'b0));
      step();
      issue = 1'b0; bm_we = 1'b0;
      if (wa < DEPTH) m_mem[wa] = wd;
   endtask

   task automatic bm_wr(int a, int d);
      bm_we = 1'b1; bm_addr = ADDR_W'(a); bm_data = 2'(d);
      step();
      bm_we = 1'b0;
      if (a < DEPTH) m_mem[a] = d;
   endtask

   task automatic pal_wr(int i, logic [23:0] d);
      pal_we = 1'b1; pal_idx = 2'(i); pal_data = d;
      step();
      pal_we = 1'b0;
      m_pal[i] = d;
   endtask

   task automatic tick(bit fs);
      vsync_tick = 1'b1; flash_start = fs;
      step();
      vsync_tick = 1'b0; flash_start = 1'b0;
      if (anim_en) begin
         m_hold++;
         if (m_hold == FRAME_HOLD) begin
            m_hold  = 0;
            m_frame = (m_frame + 1) % FRAMES;
         end
      end
      if (fs) m_flash = FLASH_LEN;
      else if (m_flash > 0) m_flash--;
      check_frame();
   endtask

   task automatic flash();
      flash_start = 1'b1;
      step();
      flash_start = 1'b0;
      m_flash = FLASH_LEN;
   endtask

   task automatic do_reset(int n);
      rst = 1'b0;
      model_reset();
      repeat (n) begin
         step();
         check_bg("reset_out");
         check_frame();
      end
   endtask

   task automatic rand_pix();
      int ox, oy, px, py;
      ox = $urandom_range(0, 1023);
      oy = $urandom_range(0, 511);
      px = ox + $urandom_range(0, SPR_W*SCALE + 4) - 2;
      py = oy + $urandom_range(0, SPR_H*SCALE + 4) - 2;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 511) py = 511;
      pix(px, py, ox, oy, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
   endtask

   // stimulus
   initial begin
      rst = 1'b0; issue = 1'b0;
      x = '0; y = '0; x0 = '0; y0 = '0; chosen = 1'b0; hflip = 1'b0;
      anim_en = 1'b0; vsync_tick = 1'b0; flash_start = 1'b0;
      bm_we = 1'b0; bm_addr = '0; bm_data = '0;
      pal_we = 1'b0; pal_idx = '0; pal_data = '0;

      do_reset(2);
      rst = 1'b1;

      for (int a = 0; a < DEPTH; a++) bm_wr(a, $urandom_range(0, 3));
      bm_wr(0, 1);
      bm_wr(1, 3);
      bm_wr(DEPTH + 5, 2);

      // origin 100,50: row 51 across the left edge and first two texels
      for (int px = 99; px <= 108; px++) pix(px, 51, 100, 50, 1'b1, 1'b0);
      pix(101, 50, 100, 50, 1'b1, 1'b0);
      pix(101, 170, 100, 50, 1'b1, 1'b0);
      pix(101, 171, 100, 50, 1'b1, 1'b0);
      // mirrored: texel 0 lands on the right edge
      for (int px = 189; px <= 198; px++) pix(px, 51, 100, 50, 1'b1, 1'b1);
      pix(101, 51, 100, 50, 1'b1, 1'b1);

      // animation over 30 ticks, then frozen
      anim_en = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick(1'b0);
         pix(101 + SCALE*(i % SPR_W), 51 + SCALE*(i % SPR_H), 100, 50, 1'b1, 1'b0);
      end
      anim_en = 1'b0;
      for (int i = 0; i < 20; i++) tick(1'b0);

      // hit flash across its whole lifetime
      flash();
      pix(101, 51, 100, 50, 1'b1, 1'b0);
      for (int i = 0; i < FLASH_LEN + 3; i++) begin
         tick(1'b0);
         pix(101, 51, 100, 50, 1'b1, 1'b0);
         pix(107, 51, 100, 50, 1'b1, 1'b0);
      end

      pal_wr(1, 24'h123456);
      pix(101, 51, 100, 50, 1'b1, 1'b0);
      pix(101, 51, 100, 50, 1'b0, 1'b0);

      // read and write the same address in one cycle
      pix_wr(101, 51, 100, 50, 0, 2);
      pix(101, 51, 100, 50, 1'b1, 1'b0);
      bm_wr(0, 1);

      // randomised mix of pixels and control traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 19))
            0:       tick(1'b0);
            1:       tick(1'b1);
            2:       flash();
            3:       pal_wr($urandom_range(0, 3), 24'($urandom));
            4:       bm_wr($urandom_range(0, 1023), $urandom_range(0, 3));
            5:       anim_en = 1'($urandom_range(0, 1));
            default: rand_pix();
         endcase
      end

      // reset in the middle of a sprite line, then release with a pixel issued
      repeat (3) step();
      x = 10'd101; y = 9'd51; x0 = 10'd100; y0 = 9'd50; chosen = 1'b1; hflip = 1'b0;
      do_reset(2);
      rst = 1'b1;
      pix(107, 51, 100, 50, 1'b1, 1'b0);
      check_bg("post_reset_out");
      pix(101, 51, 100, 50, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) rand_pix();

      repeat (4) step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected pixels never emerged, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
